// File: rtl/onehot_decoder.sv
// One-hot position decoder: collects a frame of position codes, expands each to a
// one-hot word in a small buffer, and checks the running sum against a reference.
module onehot_decoder #(
  parameter int N_WORDS = 8,
  parameter int WORD_W  = 16,
  parameter int CODE_W  = 5,
  localparam int ADDR_W = $clog2(N_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  input  logic [7:0]        expected_sum,
  input  logic              PB,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_word,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word,
  output logic [3:0]        err_cnt,
  output logic              done,
  output logic              match,
  output logic [7:0]        output_led
);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        sum;
  logic [WORD_W-1:0] buf_mem [N_WORDS];
  logic              accept;
  logic              frame_start;
  logic [WORD_W-1:0] word_dec;

  function automatic logic code_illegal(input logic [CODE_W-1:0] code);
    return int'(code) > WORD_W;
  endfunction

  function automatic logic [WORD_W-1:0] code_to_word(input logic [CODE_W-1:0] code);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (int'(code) == i + 1) w[i] = 1'b1;
    end
    return w;
  endfunction

  // Empty and illegal codes both pull the sum down by one, matching the encoder.
  function automatic logic [7:0] next_sum(input logic [7:0] s, input logic [CODE_W-1:0] code);
    if (code != '0 && !code_illegal(code)) return s + 8'(code);
    return s - 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

  function automatic logic [7:0] led_value(input logic [7:0] s, input logic pb);
    return pb ? s : {7'b0, ^s};
  endfunction

  assign accept      = in_valid && in_ready;
  assign frame_start = start && (state == IDLE || state == DONE);
  assign word_dec    = code_to_word(in_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (accept && idx == ADDR_W'(N_WORDS - 1)) state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      DONE:    if (start) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == COLLECT);
    done     = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      sum        <= 8'h00;
      err_cnt    <= 4'd0;
      match      <= 1'b0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      output_led <= 8'hFF;
    end else begin
      out_valid <= accept;
      if (frame_start) begin
        idx     <= '0;
        sum     <= 8'h00;
        err_cnt <= 4'd0;
        match   <= 1'b0;
      end
      if (accept) begin
        out_word <= word_dec;
        sum      <= next_sum(sum, in_code);
        idx      <= idx + 1'b1;
        if (code_illegal(in_code)) err_cnt <= sat_inc(err_cnt);
      end
      if (state == CHECK) match <= (sum == expected_sum);
      if (state == DONE) output_led <= led_value(sum, PB);
    end
  end

  // Readback sees the pre-write contents when the same entry is written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WORDS; i++) buf_mem[i] <= '0;
      rd_word <= '0;
    end else begin
      if (accept) buf_mem[idx] <= word_dec;
      rd_word <= buf_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed bench for onehot_decoder: hand-computed frames, LED modes, readback,
// backpressure, start-ignore and mid-frame reset.
module tb_onehot_decoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [4:0]  in_code;
  logic        in_ready;
  logic [7:0]  expected_sum;
  logic        PB;
  logic [2:0]  rd_addr;
  logic [15:0] rd_word;
  logic        out_valid;
  logic [15:0] out_word;
  logic [3:0]  err_cnt;
  logic        done;
  logic        match;
  logic [7:0]  output_led;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0]  codes [8];
  logic [15:0] words [8];
  logic [7:0]  sums  [8];

  onehot_decoder #(.N_WORDS(8), .WORD_W(16), .CODE_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .expected_sum(expected_sum), .PB(PB), .rd_addr(rd_addr),
    .rd_word(rd_word), .out_valid(out_valid), .out_word(out_word), .err_cnt(err_cnt),
    .done(done), .match(match), .output_led(output_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_a();
    codes = '{5'd0, 5'd0, 5'd9, 5'd16, 5'd1, 5'd12, 5'd0, 5'd8};
    words = '{16'h0000, 16'h0000, 16'h0100, 16'h8000, 16'h0001, 16'h0800, 16'h0000, 16'h0080};
    sums  = '{8'hFF, 8'hFE, 8'h07, 8'h17, 8'h18, 8'h24, 8'h23, 8'h2B};
  endtask

  // All tasks start and end just after a falling edge.
  task automatic run_frame(input logic [7:0] exp_sum, input logic [7:0] gap_mask,
                           input bit start_in_gap, input bit hold_after,
                           input bit exp_match, input logic [3:0] exp_err);
    int pulses;
    expected_sum = exp_sum;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("ready_collect", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      if (gap_mask[i]) begin
        in_valid = 1'b0;
        start    = start_in_gap;
        @(negedge clk);
        start = 1'b0;
        check_eq("gap_out_valid", out_valid, 0);
      end
      in_valid = 1'b1;
      in_code  = codes[i];
      @(negedge clk);
      check_eq("out_valid", out_valid, 1);
      check_eq("out_word", out_word, words[i]);
      check_eq("sum", dut.sum, sums[i]);
    end
    check_eq("ready_after_8th", in_ready, 0);
    pulses = 0;
    if (hold_after) begin
      in_code = 5'd5;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        pulses += int'(out_valid) + int'(in_ready);
      end
      check_eq("extra_accepts", pulses, 0);
    end else begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("done", done, 1);
    check_eq("match", match, exp_match);
    check_eq("err_cnt", err_cnt, exp_err);
  endtask

  task automatic check_leds(input logic [7:0] led_sum, input logic [7:0] led_par);
    PB = 1'b1;
    @(negedge clk);
    check_eq("led_sum", output_led, led_sum);
    PB = 1'b0;
    @(negedge clk);
    check_eq("led_parity", output_led, led_par);
  endtask

  task automatic sweep(input bit zeros);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      @(negedge clk);
      check_eq("rd_word", rd_word, zeros ? 16'h0000 : words[a]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_code = '0;
    expected_sum = '0; PB = 1'b1; rd_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_led", output_led, 8'hFF);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_match", match, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_word", out_word, 0);
    check_eq("rst_rd_word", rd_word, 0);
    check_eq("rst_err", err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", in_ready, 0);

    // Scenario A: mixed codes, back-to-back.
    load_a();
    run_frame(8'h2B, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
    check_leds(8'h2B, 8'h00);
    sweep(1'b0);

    // Scenario B: all 16s, with a start pulse during a COLLECT gap that must be ignored.
    codes = '{default: 5'd16};
    words = '{default: 16'h8000};
    sums  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    run_frame(8'h7F, 8'h10, 1'b1, 1'b0, 1'b0, 4'd0);
    check_leds(8'h80, 8'h01);

    // Scenario C: all empty codes.
    codes = '{default: 5'd0};
    words = '{default: 16'h0000};
    sums  = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8};
    run_frame(8'hF8, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
    check_leds(8'hF8, 8'h01);

    // Scenario D: illegal codes mixed in.
    codes = '{5'd17, 5'd31, 5'd3, 5'd20, 5'd0, 5'd5, 5'd1, 5'd2};
    words = '{16'h0000, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 16'h0010, 16'h0001, 16'h0002};
    sums  = '{8'hFF, 8'hFE, 8'h01, 8'h00, 8'hFF, 8'h04, 8'h05, 8'h07};
    run_frame(8'h07, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
    check_leds(8'h07, 8'h01);
    sweep(1'b0);

    // Scenario A again with idle gaps and in_valid held high after the frame.
    load_a();
    run_frame(8'h2B, 8'b1011_0110, 1'b0, 1'b1, 1'b1, 4'd0);
    check_leds(8'h2B, 8'h00);
    sweep(1'b0);

    // Reset after four accepts of scenario A.
    expected_sum = 8'h2B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = codes[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_led", output_led, 8'hFF);
    check_eq("mid_rst_sum", dut.sum, 8'h00);
    check_eq("mid_rst_ready", in_ready, 0);
    check_eq("mid_rst_rd_word", rd_word, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_idle_ready", in_ready, 0);
    sweep(1'b1);
    run_frame(8'h2B, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
    check_leds(8'h2B, 8'h00);
    sweep(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/onehot_decoder.md
Name: onehot_decoder

Overview:
- Decoding end of the one-hot position scheme: accepts a frame of 8 five-bit position codes over a valid/ready handshake and expands each to a 16-bit one-hot word stored in an 8-entry word buffer.
- Builds the same 8-bit running sum the encoder builds, compares it against an expected sum, and drives the board LEDs with the sum or its parity, selected by PB.
- Sits between the code source (UART/switch front end) and the LED/readback logic.

Parameters:
- N_WORDS, 8, words per frame and buffer depth; power of two.
- WORD_W, 16, one-hot word width.
- CODE_W, 5, code width; must satisfy 2^CODE_W > WORD_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  begin a frame; honoured only in IDLE or DONE.
- in_valid  in  1  in_code is valid.
- in_code  in  CODE_W  position code: 0 means empty word; 1..16 means bit (code-1); 17..31 is illegal.
- in_ready  out  1  high only in COLLECT.
- expected_sum  in  8  reference checksum; sampled in CHECK.
- PB  in  1  LED select: 1 shows the sum, 0 shows parity.
- rd_addr  in  log2(N_WORDS)  buffer readback address.
- rd_word  out  WORD_W  buffer readback data, registered.
- out_valid  out  1  one-cycle pulse accompanying out_word.
- out_word  out  WORD_W  most recently decoded word.
- err_cnt  out  4  illegal codes seen in the current frame; saturates at 15.
- done  out  1  high in DONE.
- match  out  1  sum == expected_sum; valid while done=1.
- output_led  out  8  LED drive.

Behaviour:
- Async reset values:
  - state=IDLE, idx=0, sum=0x00, err_cnt=0
  - out_word=0, out_valid=0, rd_word=0, done=0, match=0
  - all buffer entries=0, output_led=8'hFF
- FSM states: IDLE, COLLECT, CHECK, DONE.
- IDLE: in_ready=0. When start=1, go to COLLECT next cycle and clear idx, sum, err_cnt, match, done. Buffer contents are kept.
- COLLECT: in_ready=1. An accept occurs when in_valid and in_ready are both 1 on a clk edge. Each accept:
  - Code 1..16: word = 1<<(code-1); sum <= sum + code (mod 256).
  - Code 0: word = 0; sum <= sum - 1 (mod 256, so 0x00 becomes 0xFF).
  - Code 17..31: word = 0; sum <= sum - 1; err_cnt increments, saturating at 15.
  - buf[idx] <= word; out_word <= word; out_valid=1 in the cycle after the accept; idx increments.
- When in_valid=0 in COLLECT: no state change and out_valid=0.
- The accept with idx = N_WORDS-1 moves the FSM to CHECK and idx wraps to 0. in_ready drops in the cycle after that accept; no ninth code is taken.
- start asserted in COLLECT or CHECK is ignored.
- CHECK: lasts exactly one cycle. match <= (sum == expected_sum). Go to DONE.
- DONE: done=1, match held.
  - output_led, updated every cycle: PB=1 gives sum; PB=0 gives {7'b0, XOR-reduce(sum)}.
  - start=1 behaves as in IDLE and goes to COLLECT. output_led holds its last value until the next DONE.
- Outside DONE, output_led holds its previous value.
- Readback: rd_word <= buf[rd_addr] every cycle in all states, 1-cycle latency. A write and a read of the same address in one cycle return the old data.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded and the buffer is cleared.

Test Plan:
- Reset, start, then codes 0,0,9,16,1,12,0,8 back-to-back with expected_sum=0x2B. Required:
  - Buffer holds 0000,0000,0100,8000,0001,0800,0000,0080.
  - Sum sequence is FF,FE,07,17,18,24,23,2B.
  - match=1, err_cnt=0.
  - PB=1 gives LED 0x2B; PB=0 gives LED 0x00.
- Eight codes of 16 with expected_sum=0x7F -> sum=0x80, match=0, PB=1 LED=0x80, PB=0 LED=0x01; eight codes of 0 in the next frame -> sum=0xF8.
- Codes 17,31,3,20,0,5,1,2 -> stored words 0,0,0004,0,0,0010,0001,0002; err_cnt=3; sum=0xFF,FE,01,00,FF,04,05,07 -> 0x07.
- Backpressure and idle gaps: in_valid toggled randomly with in_valid held high for 10 cycles after the 8th code -> exactly 8 accepts, in_ready=0 after the 8th, same buffer and sum as the gap-free run, out_valid pulses=8.
- Reset pulled low after 4 accepts of the first scenario -> output_led=0xFF, sum=0, buffer all 0, state IDLE; restart gives full-frame results identical to the first scenario.
- Readback: after the first scenario, sweep rd_addr 0..7 -> rd_word matches the buffer one cycle later; start during COLLECT is ignored (idx is not cleared).
